// File: rtl/yj_sync_fifo_pkg.sv
// Shared definitions for the yj_sync_fifo block: default geometry, depth
// derivation, threshold range checks and the per-cycle operation decode type.
// No ports; imported by the interface, the storage array and the FIFO top.
package yj_sync_fifo_pkg;

    // Default geometry: 32-bit words, 8 entries.
    localparam int DEF_DW        = 32;
    localparam int DEF_AW        = 3;
    localparam int DEF_AFULL_TH  = 6;
    localparam int DEF_AEMPTY_TH = 1;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // almost_full threshold must lie in 1..DEPTH.
    function automatic bit afull_th_ok(input int aw, input int th);
        return (th >= 1) && (th <= fifo_depth(aw));
    endfunction

    // almost_empty threshold must lie in 0..DEPTH-1.
    function automatic bit aempty_th_ok(input int aw, input int th);
        return (th >= 0) && (th <= fifo_depth(aw) - 1);
    endfunction

    // Requests that are actually accepted this cycle.
    typedef struct packed {
        logic push;
        logic pop;
    } fifo_op_t;

endpackage

// File: rtl/yj_sync_fifo_if.sv
// Push/pop/status bundle of the single-clock FIFO.
// master = requester side (drives flush/w_en/w_data/r_en), slave = the FIFO.
// overflow/underflow exist only when YJ_FIFO_ERR_EN is defined.
interface yj_sync_fifo_if
    import yj_sync_fifo_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic          flush;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
`ifdef YJ_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    modport master (
`ifdef YJ_FIFO_ERR_EN
        input  overflow,
        input  underflow,
`endif
        output flush,
        output w_en,
        output w_data,
        output r_en,
        input  r_data,
        input  r_valid,
        input  fifoFull,
        input  fifoEmpty,
        input  almost_full,
        input  almost_empty,
        input  level
    );

    modport slave (
`ifdef YJ_FIFO_ERR_EN
        output overflow,
        output underflow,
`endif
        input  flush,
        input  w_en,
        input  w_data,
        input  r_en,
        output r_data,
        output r_valid,
        output fifoFull,
        output fifoEmpty,
        output almost_full,
        output almost_empty,
        output level
    );

endinterface

// File: rtl/yj_fifo_ram.sv
// DEPTH x DW register-array storage, one write port, registered read port.
// Latency: write visible the cycle after we; rdata updates one cycle after re.
// Backpressure: none here, the caller only issues legal accesses.
// Ports: CLK, RSTn (async, active low), we/waddr/wdata, re/raddr, rdata.

// Single enabled register with asynchronous active-low reset to zero.
module basic_reg_clk_p #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module yj_fifo_ram
    import yj_sync_fifo_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        basic_reg_clk_p #(.W(DW)) u_ent (
            .clk   (CLK),
            .rst_n (RSTn),
            .en    (we && (waddr == AW'(i))),
            .d     (wdata),
            .q     (mem[i])
        );
    end

    // Read data holds its last value between reads.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/yj_sync_fifo.sv
// Parametrised single-clock FIFO with level, almost-full/empty and synchronous flush.
// Latency: pushed word poppable next cycle; r_data/r_valid one cycle after accepted pop.
// Backpressure: push refused while fifoFull, pop refused while fifoEmpty, flush wins over both.
// Ports: CLK, RSTn (async, active low), bus (yj_sync_fifo_if.slave).
// Optional: define YJ_FIFO_ERR_EN for sticky overflow/underflow flags.
module yj_sync_fifo
    import yj_sync_fifo_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic          CLK,
    input  logic          RSTn,
    yj_sync_fifo_if.slave bus
);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] PTR_INC = (AW+1)'(1);

    if (!afull_th_ok(AW, AFULL_TH)) begin : g_bad_afull_th
        $error("yj_sync_fifo: AFULL_TH out of range 1..DEPTH");
    end
    if (!aempty_th_ok(AW, AEMPTY_TH)) begin : g_bad_aempty_th
        $error("yj_sync_fifo: AEMPTY_TH out of range 0..DEPTH-1");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   lvl;
    logic          full;
    logic          empty;
    logic          r_valid_q;
    logic [DW-1:0] ram_rdata;
    fifo_op_t      op;

    // Status comes from the registered pointers only, never from w_en/r_en.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        lvl   = wr_ptr - rd_ptr;
    end

    // Full refuses the push and empty refuses the pop, so simultaneous
    // push+pop at either extreme resolves to a single accepted operation.
    always_comb begin
        op      = '0;
        op.push = bus.w_en & ~full  & ~bus.flush;
        op.pop  = bus.r_en & ~empty & ~bus.flush;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (op.push) wr_ptr <= wr_ptr + PTR_INC;
            if (op.pop)  rd_ptr <= rd_ptr + PTR_INC;
        end
    end

    // One-cycle pulse per accepted pop; op.pop is already forced low by flush.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= op.pop;
        end
    end

    // Storage is not cleared by flush; only the pointers move.
    yj_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .we    (op.push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.w_data),
        .re    (op.pop),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.r_data       = ram_rdata;
    assign bus.r_valid      = r_valid_q;
    assign bus.fifoFull     = full;
    assign bus.fifoEmpty    = empty;
    assign bus.level        = lvl;
    assign bus.almost_full  = (lvl >= AF_LVL);
    assign bus.almost_empty = (lvl <= AE_LVL);

`ifdef YJ_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky until flush or reset; requests during a flush cycle never count.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.w_en && full)  ovf_q <= 1'b1;
            if (bus.r_en && empty) udf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`endif

endmodule
